// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, branch flush, memory-wait freeze and timeout
//
// Purpose:
//   Generates the PC / pipeline-register control signals for a 5-stage pipeline.
//   The priority order is: reset, latched memory error, memory stall, taken branch, load-use, default.
//   A memory access that is not acknowledged within MEM_TIMEOUT wait cycles latches a sticky error.
//   The error freezes the pipeline until reset.
//
// Parameters:
//   MEM_TIMEOUT     wait-timer value at which a still-busy access becomes an error (2..255)
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   IFID_RS1, IFID_RS2              source registers of the instruction in ID
//   IDEX_MemRead, IDEX_RD           load flag / destination of the instruction in EX
//   EXMEM_Branch, EXMEM_Zero        branch flag / ALU zero of the instruction in MEM
//   EXMEM_MemRead, EXMEM_MemWrite   data-memory access of the instruction in MEM
//   mem_ready                       data memory completed the current access
//   PCWrite, IFID_Write             PC and IF/ID update enables
//   IFID_Flush, IDEX_Flush,
//   EXMEM_Flush                     zero the named pipeline register on the next edge
//   PCSrc                           select branch target as next PC
//   Freeze                          hold every pipeline register and the PC
//   mem_err                         sticky memory-timeout error
//   stall_cnt, flush_cnt            (HAZARD_PERF_CNT_EN only) saturating 32-bit counters:
//                                   cycles with PCWrite=0, and taken-branch cycles
//
// Build option:
//   HAZARD_PERF_CNT_EN   adds the stall_cnt / flush_cnt performance counters

module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IFID_RS1,
  input  logic [4:0] IFID_RS2,
  input  logic       IDEX_MemRead,
  input  logic [4:0] IDEX_RD,
  input  logic       EXMEM_Branch,
  input  logic       EXMEM_Zero,
  input  logic       EXMEM_MemRead,
  input  logic       EXMEM_MemWrite,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Flush,
  output logic       EXMEM_Flush,
  output logic       PCSrc,
  output logic       Freeze,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  state_t     state, state_next;
  logic [7:0] timer, timer_next;

  logic mem_busy;
  logic branch_taken;
  logic load_use;

  // Hazard detection terms
  assign mem_busy     = (EXMEM_MemRead | EXMEM_MemWrite) & ~mem_ready;
  assign branch_taken = EXMEM_Branch & EXMEM_Zero;
  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign load_use     = IDEX_MemRead && (IDEX_RD != 5'd0) &&
                        ((IDEX_RD == IFID_RS1) || (IDEX_RD == IFID_RS2));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      timer <= 8'd0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // Next state and outputs
  always_comb begin
    state_next  = state;
    timer_next  = timer;
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    PCSrc       = 1'b0;
    Freeze      = 1'b0;
    mem_err     = 1'b0;

    if (reset) begin
      // Flush everything and hold the PC while reset is asserted.
      // The registers themselves are cleared in the always_ff block.
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
      state_next  = RUN;
      timer_next  = 8'd0;
    end else begin
      unique case (state)
        ERROR: begin
          // Terminal until reset: inputs are ignored.
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          Freeze     = 1'b1;
          mem_err    = 1'b1;
        end

        RUN, MEM_WAIT: begin
          if (mem_busy) begin
            // A memory stall outranks branches and load-use.
            // The pipeline is frozen as a whole, so nothing is flushed.
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            Freeze     = 1'b1;
            if (state == RUN) begin
              state_next = MEM_WAIT;
              timer_next = 8'd1;
            end else if (timer == TIMEOUT_VAL) begin
              state_next = ERROR;
            end else begin
              timer_next = timer + 8'd1;
            end
          end else begin
            // Either running normally or the access just completed.
            // In both cases the ordinary hazard rules apply this cycle.
            state_next = RUN;
            timer_next = 8'd0;
            if (branch_taken) begin
              PCSrc       = 1'b1;
              IFID_Flush  = 1'b1;
              IDEX_Flush  = 1'b1;
              EXMEM_Flush = 1'b1;
            end else if (load_use) begin
              // Hold the PC and IF/ID for one cycle.
              // Insert a bubble into EX.
              PCWrite    = 1'b0;
              IFID_Write = 1'b0;
              IDEX_Flush = 1'b1;
            end
          end
        end

        default: begin
          // Unused encoding: freeze for one cycle and recover to RUN.
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          Freeze     = 1'b1;
          state_next = RUN;
          timer_next = 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating performance counters.
  // A taken branch is exactly the cycle that drives PCSrc.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!PCWrite && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (PCSrc && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized scoreboard bench for hazard_ctrl against a behavioural model

module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] IFID_RS1 = '0, IFID_RS2 = '0, IDEX_RD = '0;
  logic       IDEX_MemRead = 0, EXMEM_Branch = 0, EXMEM_Zero = 0;
  logic       EXMEM_MemRead = 0, EXMEM_MemWrite = 0, mem_ready = 1;
  logic       PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, PCSrc, Freeze, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .IFID_RS1(IFID_RS1), .IFID_RS2(IFID_RS2),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RD(IDEX_RD),
    .EXMEM_Branch(EXMEM_Branch), .EXMEM_Zero(EXMEM_Zero),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
    .PCSrc(PCSrc), .Freeze(Freeze), .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected output vector: {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, PCSrc, Freeze, mem_err}
  typedef struct {
    logic [7:0]  o;
    int unsigned sc;
    int unsigned fc;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state.
  // busy_streak is the number of consecutive busy cycles seen so far.
  // err_latched records that a timeout has occurred.
  int          busy_streak = 0;
  bit          err_latched = 0;
  int unsigned m_stall = 0, m_flush = 0;

  task automatic step();
    exp_t e;
    bit   busy, lu;
    busy = (EXMEM_MemRead | EXMEM_MemWrite) & ~mem_ready;
    lu   = IDEX_MemRead && IDEX_RD != 0 && (IDEX_RD == IFID_RS1 || IDEX_RD == IFID_RS2);
    e.sc  = m_stall;
    e.fc  = m_flush;
    e.cyc = cyc;
    if (reset) begin
      e.o = 8'b0011_1000;
    end else if (err_latched) begin
      e.o = 8'b0000_0011;
    end else if (busy) begin
      e.o = 8'b0000_0010;
    end else if (EXMEM_Branch && EXMEM_Zero) begin
      e.o = 8'b1111_1100;
    end else if (lu) begin
      e.o = 8'b0001_0000;
    end else begin
      e.o = 8'b1100_0000;
    end
    q.push_back(e);

    // Advance the model across the coming clock edge.
    if (reset) begin
      busy_streak = 0;
      err_latched = 0;
      m_stall     = 0;
      m_flush     = 0;
    end else begin
      if (!err_latched) begin
        if (busy) begin
          busy_streak++;
          // The first busy cycle starts the wait count at one.
          // The timeout fires on the busy cycle after the count has reached TIMEOUT.
          if (busy_streak > TIMEOUT) err_latched = 1;
        end else begin
          busy_streak = 0;
        end
      end
      if (e.o[7] == 1'b0) m_stall++;
      if (e.o[2] == 1'b1) m_flush++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic idmr, input logic [4:0] idrd, input logic br, input logic z,
                       input logic mr, input logic mw, input logic rdy);
    reset          = rst;
    IFID_RS1       = rs1;
    IFID_RS2       = rs2;
    IDEX_MemRead   = idmr;
    IDEX_RD        = idrd;
    EXMEM_Branch   = br;
    EXMEM_Zero     = z;
    EXMEM_MemRead  = mr;
    EXMEM_MemWrite = mw;
    mem_ready      = rdy;
    step();
  endtask

  // Monitor: the outputs are valid every cycle, so one queued expectation is compared per negedge.
  exp_t        mx;
  logic [7:0]  act;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mx  = q.pop_front();
      act = {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, PCSrc, Freeze, mem_err};
      n_cmp++;
      if (act !== mx.o) begin
        n_fail++;
        $display("FAIL outs cyc=%0d got=%b want=%b", mx.cyc, act, mx.o);
      end
`ifdef HAZARD_PERF_CNT_EN
      n_cmp++;
      if (stall_cnt !== mx.sc || flush_cnt !== mx.fc) begin
        n_fail++;
        $display("FAIL counters cyc=%0d got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 mx.cyc, stall_cnt, flush_cnt, mx.sc, mx.fc);
      end
`endif
    end
  end

  int burst = 0;

  initial begin
    @(posedge clk);
    #1;
    // Reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Load-use on RS2, then the load leaves EX
    drive(0, 1, 5, 1, 5, 0, 0, 0, 0, 1);
    drive(0, 1, 5, 0, 5, 0, 0, 0, 0, 1);
    // A load into x0 never stalls
    drive(0, 0, 3, 1, 0, 0, 0, 0, 0, 1);
    // Branch and load-use in the same cycle: only the branch response appears
    drive(0, 5, 0, 1, 5, 1, 1, 0, 0, 1);
    // Load-use on RS1
    drive(0, 7, 2, 1, 7, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Three busy cycles, then ready while a load-use is pending
    repeat (3) drive(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    drive(0, 4, 0, 1, 4, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // A write held unacknowledged reaches the timeout and sticks there
    repeat (8) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 3, 3, 1, 3, 1, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Reset clears the error
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Two load-use stalls and one branch after a clean reset
    drive(0, 6, 1, 1, 6, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 9, 1, 9, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic with occasional reset and unacknowledged-memory bursts
    for (int i = 0; i < 3000; i++) begin
      logic rst, rdy;
      if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(1, 8);
      rst = ($urandom_range(0, 149) == 0);
      rdy = (burst > 0) ? 1'b0 : ($urandom_range(0, 7) != 0);
      if (burst > 0) burst--;
      drive(rst, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), rdy);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
